// File: rtl/aes_pkg.sv
// Shared types and constant tables for the serial AES S-box stage.
// Holds the FSM state encoding, the forward S-box and the key-schedule round constants.
package aes_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      BYTE0,
      BYTE1,
      BYTE2,
      BYTE3,
      DONE
   } sbox_state_t;

   localparam byte_t SBOX_TABLE [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t RC_TABLE [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   // Rounds past the configured limit yield a zero constant even where the table has an entry.
   function automatic logic [31:0] rcon_word(input logic [3:0] rnd, input int unsigned rounds);
      logic [31:0] w;
      w = '0;
      if (rnd != 4'd0 && 32'(rnd) <= rounds) begin
         w = {RC_TABLE[rnd], 24'h000000};
      end
      return w;
   endfunction

endpackage

// File: rtl/aes_sbox_rom.sv
// Combinational forward AES S-box lookup.
module aes_sbox_rom
   import aes_pkg::*;
(
   input  logic [7:0] addr_i,
   output logic [7:0] data_o
);

   assign data_o = SBOX_TABLE[addr_i];

endmodule

// File: rtl/aes_sbox_stage.sv
// Memory-stage AES SubWord/RotWord unit: one shared S-box, one byte per cycle,
// with a stall request covering the whole operation and a one-cycle done pulse.
module aes_sbox_stage
   import aes_pkg::*;
#(
   parameter int unsigned ROUNDS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rot,
   input  logic [31:0] operand,
   input  logic [3:0]  round,
   output logic [31:0] sbox,
   output logic [31:0] rcon,
   output logic        stall,
   output logic        busy,
   output logic        done
);

   sbox_state_t state_q, state_d;
   logic [31:0] w_q, w_d;
   logic [31:0] sbox_q, sbox_d;
   logic [31:0] rcon_q, rcon_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        accept;
   byte_t       rom_addr;
   byte_t       rom_data;

   assign accept = start && (state_q == IDLE || state_q == DONE);

   always_comb begin
      rom_addr = w_q[7:0];
      case (state_q)
         BYTE1:   rom_addr = w_q[15:8];
         BYTE2:   rom_addr = w_q[23:16];
         BYTE3:   rom_addr = w_q[31:24];
         default: rom_addr = w_q[7:0];
      endcase
   end

   aes_sbox_rom u_rom (
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      sbox_d  = sbox_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               w_d     = rot ? {operand[23:0], operand[31:24]} : operand;
               rcon_d  = rcon_word(round, ROUNDS);
               sbox_d  = '0;
               busy_d  = 1'b1;
               state_d = BYTE0;
            end
         end
         BYTE0: begin
            sbox_d[7:0] = rom_data;
            busy_d      = 1'b1;
            state_d     = BYTE1;
         end
         BYTE1: begin
            sbox_d[15:8] = rom_data;
            busy_d       = 1'b1;
            state_d      = BYTE2;
         end
         BYTE2: begin
            sbox_d[23:16] = rom_data;
            busy_d        = 1'b1;
            state_d       = BYTE3;
         end
         BYTE3: begin
            sbox_d[31:24] = rom_data;
            done_d        = 1'b1;
            state_d       = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         sbox_q  <= '0;
         rcon_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         sbox_q  <= sbox_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign sbox  = sbox_q;
   assign rcon  = rcon_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign stall = accept | busy_q;

endmodule

// File: tb/tb_aes_sbox_stage.sv
// Directed-vector bench for aes_sbox_stage: reset, latency/stall timing,
// S-box/rcon values, RotWord, ignored and back-to-back starts, mid-op reset.
module tb_aes_sbox_stage;

   logic        clk;
   logic        rst;
   logic        start;
   logic        rot;
   logic [31:0] operand;
   logic [3:0]  round;
   logic [31:0] sbox;
   logic [31:0] rcon;
   logic        stall;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;

   aes_sbox_stage #(.ROUNDS(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rot     (rot),
      .operand (operand),
      .round   (round),
      .sbox    (sbox),
      .rcon    (rcon),
      .stall   (stall),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives a request in the current cycle (between a negedge and the next posedge).
   task automatic issue(input logic [31:0] op, input logic r, input logic [3:0] rnd);
      @(negedge clk);
      start   = 1'b1;
      rot     = r;
      operand = op;
      round   = rnd;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rot = 1'b0; operand = '0; round = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({sbox, rcon, stall, busy, done} !== 67'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got sbox=%h rcon=%h stall=%b busy=%b done=%b, want all 0",
                  sbox, rcon, stall, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_word();
      issue(32'h00000000, 1'b0, 4'd1);
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_stall_c0: got %b want 1", stall);
      end
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         vectors++;
         if (stall !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_busy_c%0d: got stall=%b busy=%b done=%b want 1 1 0", c, stall, busy, done);
         end
         vectors++;
         if (rcon !== 32'h01000000) begin
            miscompares++;
            $display("FAIL zero_rcon_c%0d: got %h want 01000000", c, rcon);
         end
         @(negedge clk);
      end
      vectors++;
      if (done !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_done_c5: got done=%b stall=%b busy=%b want 1 0 0", done, stall, busy);
      end
      vectors++;
      if (sbox !== 32'h63636363) begin
         miscompares++;
         $display("FAIL zero_sbox: got %h want 63636363", sbox);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || sbox !== 32'h63636363) begin
         miscompares++;
         $display("FAIL zero_hold: got done=%b sbox=%h want 0 63636363", done, sbox);
      end
   endtask

   task automatic test_mixed();
      int cyc;
      issue(32'h53FF0100, 1'b0, 4'd10);
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc !== 5) begin
         miscompares++;
         $display("FAIL mixed_latency: got %0d want 5", cyc);
      end
      vectors++;
      if (sbox !== 32'hED167C63 || rcon !== 32'h36000000) begin
         miscompares++;
         $display("FAIL mixed_result: got sbox=%h rcon=%h want ED167C63 36000000", sbox, rcon);
      end
   endtask

   task automatic test_rotword();
      int cyc;
      issue(32'h53FF0100, 1'b1, 4'd0);
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (sbox !== 32'h00000000) begin
         miscompares++;
         $display("FAIL rot_clear: got sbox=%h want 00000000", sbox);
      end
      cyc = 1;
      while (done !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc !== 5 || sbox !== 32'h167C63ED || rcon !== 32'h00000000) begin
         miscompares++;
         $display("FAIL rot_result: got lat=%0d sbox=%h rcon=%h want 5 167C63ED 00000000", cyc, sbox, rcon);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      issue(32'h53FF0100, 1'b0, 4'd10);
      @(negedge clk);
      start = 1'b0;                     // BYTE0
      @(negedge clk);                   // BYTE1: stray request
      start = 1'b1; operand = 32'hFFFFFFFF; round = 4'd3; rot = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);        // DONE cycle
      vectors++;
      if (done !== 1'b1 || sbox !== 32'hED167C63 || rcon !== 32'h36000000) begin
         miscompares++;
         $display("FAIL ignore_start: got done=%b sbox=%h rcon=%h want 1 ED167C63 36000000", done, sbox, rcon);
      end
      start = 1'b1; operand = 32'h10101010; round = 4'd11; rot = 1'b0;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_stall_done: got %b want 1", stall);
      end
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc !== 5 || sbox !== 32'hCACACACA || rcon !== 32'h00000000) begin
         miscompares++;
         $display("FAIL b2b_result: got lat=%0d sbox=%h rcon=%h want 5 CACACACA 00000000", cyc, sbox, rcon);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      int cyc;
      issue(32'h53FF0100, 1'b1, 4'd10);
      @(negedge clk);
      start = 1'b0;                     // BYTE0
      repeat (2) @(negedge clk);        // BYTE2
      vectors++;
      if (sbox !== 32'h000063ED) begin
         miscompares++;
         $display("FAIL midop_partial: got %h want 000063ED", sbox);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({sbox, rcon, stall, busy, done} !== 67'd0) begin
         miscompares++;
         $display("FAIL midop_reset: got sbox=%h rcon=%h stall=%b busy=%b done=%b want all 0",
                  sbox, rcon, stall, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sbox !== 32'h0) begin
         miscompares++;
         $display("FAIL midop_idle: got busy=%b done=%b sbox=%h want 0 0 0", busy, done, sbox);
      end
      issue(32'h10101010, 1'b0, 4'd2);
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc !== 5 || sbox !== 32'hCACACACA || rcon !== 32'h02000000) begin
         miscompares++;
         $display("FAIL midop_restart: got lat=%0d sbox=%h rcon=%h want 5 CACACACA 02000000", cyc, sbox, rcon);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_zero_word();
      test_mixed();
      test_rotword();
      test_back_to_back();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
